// File: rtl/iobus_uart_tx_if.sv
// CPU IOBUS connection for the UART transmitter: the CPU (master) drives
// address, write data and write strobe; the responder (slave) returns read data.
interface iobus_uart_tx_if;
    // IOBUS_WR is a single-cycle write strobe qualified by IOBUS_ADDR and
    // IOBUS_OUT on the same posedge; the responder is always ready, so writes
    // never stall and IOBUS_IN is valid combinationally in the same cycle.
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;

    modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input IOBUS_IN);
    modport slave  (input IOBUS_ADDR, input IOBUS_OUT, input IOBUS_WR, output IOBUS_IN);
endinterface

// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU IOBUS with a TX FIFO.
// Optional even parity bit when IOBUS_UART_PARITY_EN is defined.
module iobus_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    iobus_uart_tx_if.slave       bus,
    output logic                 TX,
    output logic                 TX_IDLE,
    output logic [2:0]           state_dbg
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

`ifdef IOBUS_UART_PARITY_EN
    localparam logic PARITY_CAP = 1'b1;
`else
    localparam logic PARITY_CAP = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            ovf;
    logic [15:0]     div, reload, timer;
    logic [7:0]      shreg;
    logic [2:0]      bit_idx;
    logic            tx_q;

    logic            hit, wr_hit, push_req, push_ok, pop, empty, full, busy;
    logic [1:0]      sel;
    logic [3:0]      count4;
    logic            unused_bits;

    assign hit      = (bus.IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign sel      = bus.IOBUS_ADDR[3:2];
    assign wr_hit   = hit && bus.IOBUS_WR;
    assign push_req = wr_hit && (sel == 2'd0);
    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign busy     = (state != S_IDLE);
    // The serializer takes a byte when idle, or at the last stop-bit cycle for back-to-back frames.
    assign pop      = !empty && ((state == S_IDLE) || ((state == S_STOP) && (timer == 16'd0)));
    assign push_ok  = push_req && (!full || pop);

    assign unused_bits = &{1'b0, bus.IOBUS_ADDR[1:0], bus.IOBUS_OUT[31:16]};

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= bus.IOBUS_OUT[7:0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            div    <= DEFAULT_DIV;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && !push_ok)
                ovf <= 1'b1;
            else if (wr_hit && (sel == 2'd1) && bus.IOBUS_OUT[7])
                ovf <= 1'b0;
            if (wr_hit && (sel == 2'd2))
                div <= bus.IOBUS_OUT[15:0];
        end
    end

    // TX is registered from the current state, so the line lags the state by one cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            tx_q    <= 1'b1;
            timer   <= '0;
            reload  <= '0;
            shreg   <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (!empty) begin
                        shreg  <= mem[rd_ptr];
                        reload <= div;
                        timer  <= div;
                        state  <= S_START;
                    end
                end
                S_START: begin
                    tx_q <= 1'b0;
                    if (timer == 16'd0) begin
                        timer   <= reload;
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                S_DATA: begin
                    tx_q <= shreg[bit_idx];
                    if (timer == 16'd0) begin
                        timer   <= reload;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef IOBUS_UART_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                S_PARITY: begin
                    tx_q <= ^shreg;
                    if (timer == 16'd0) begin
                        timer <= reload;
                        state <= S_STOP;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (timer == 16'd0) begin
                        if (!empty) begin
                            shreg  <= mem[rd_ptr];
                            reload <= div;
                            timer  <= div;
                            state  <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        count4 = (32'(count) > 32'd15) ? 4'hF : 4'(count);
    end

    always_comb begin
        bus.IOBUS_IN = '0;
        if (hit) begin
            case (sel)
                2'd1:    bus.IOBUS_IN = {23'b0, PARITY_CAP, ovf, busy, full, empty, count4};
                2'd2:    bus.IOBUS_IN = {16'b0, div};
                default: bus.IOBUS_IN = '0;
            endcase
        end
    end

    assign TX        = tx_q;
    assign TX_IDLE   = empty && (state == S_IDLE);
    assign state_dbg = state;
endmodule

// File: tb/tb_iobus_uart_tx.sv
// Self-checking bench for iobus_uart_tx: randomized bytes/divisors against a
// frame-level waveform model; honours IOBUS_UART_PARITY_EN when defined.
module tb_iobus_uart_tx;
    localparam logic [31:0] BASE  = 32'h1100_0100;
    localparam logic [31:0] A_TX  = BASE;
    localparam logic [31:0] A_ST  = BASE + 32'h4;
    localparam logic [31:0] A_BD  = BASE + 32'h8;
    localparam logic [31:0] A_RSV = BASE + 32'hC;
`ifdef IOBUS_UART_PARITY_EN
    localparam logic [31:0] CAP = 32'h100;
    localparam int FRAME_BITS = 11;
`else
    localparam logic [31:0] CAP = 32'h0;
    localparam int FRAME_BITS = 10;
`endif

    logic       clk;
    logic       rst_n;
    logic       tx;
    logic       tx_idle;
    logic [2:0] state_dbg;

    iobus_uart_tx_if bus ();

    iobus_uart_tx dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .bus       (bus),
        .TX        (tx),
        .TX_IDLE   (tx_idle),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [0:0] exp_q[$];
    logic [0:0] tx_log[$];
    logic       capture = 1'b0;

    // Line monitor: one sample per cycle, 2 ns after the active edge.
    always @(posedge clk) begin
        if (capture) begin
            #2;
            tx_log.push_back(tx);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks: called on a falling clock edge
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.IOBUS_ADDR = addr;
        bus.IOBUS_OUT  = data;
        bus.IOBUS_WR   = 1'b1;
        @(negedge clk);
        bus.IOBUS_WR   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus.IOBUS_ADDR = addr;
        bus.IOBUS_WR   = 1'b0;
        #1;
        data = bus.IOBUS_IN;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a frame is start, 8 data bits LSB first, [even parity], stop,
    // each bit held d+1 cycles.
    task automatic add_frame(input logic [7:0] b, input int d);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef IOBUS_UART_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[k])
            repeat (d + 1) exp_q.push_back(bits[k]);
    endtask

    // Line stays high for the write edge and the pop edge before the start bit.
    task automatic begin_capture();
        tx_log.delete();
        exp_q.delete();
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        capture = 1'b1;
    endtask

    task automatic compare_wave(input string tag);
        int nbad;
        capture = 1'b0;
        nbad = 0;
        check({tag, "_len"}, (exp_q.size() <= tx_log.size()) ? 32'd1 : 32'd0, 32'd1);
        while (exp_q.size() < tx_log.size()) exp_q.push_back(1'b1);
        foreach (tx_log[i])
            if (tx_log[i] !== exp_q[i]) nbad++;
        check({tag, "_bits"}, nbad, 0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  bytes[$];
        int          d;
        int          n;

        bus.IOBUS_ADDR = '0;
        bus.IOBUS_OUT  = '0;
        bus.IOBUS_WR   = 1'b0;
        rst_n = 1'b0;
        wait_cycles(3);
        check("rst_tx", tx, 1);
        check("rst_tx_idle", tx_idle, 1);
        rst_n = 1'b1;
        wait_cycles(1);
        bus_read(A_ST, rd);  check("rst_status", rd, 32'h10 | CAP);
        bus_read(A_BD, rd);  check("rst_bauddiv", rd, 32'd867);
        bus_read(A_TX, rd);  check("rd_txdata", rd, 0);
        @(negedge clk);

        // single frame, div=3, 0xA5
        bus_write(A_BD, 32'd3);
        begin_capture();
        bus_write(A_TX, 32'hA5);
        add_frame(8'hA5, 3);
        wait_cycles(FRAME_BITS * 4 + 6);
        compare_wave("a5_div3");
        check("a5_tx_idle", tx_idle, 1);

        // back-to-back 0x41, 0x42 with div=0
        bus_write(A_BD, 32'd0);
        begin_capture();
        bus_write(A_TX, 32'h41);
        bus_write(A_TX, 32'h42);
        bus_read(A_ST, rd);  check("b2b_status_mid", rd, 32'h41 | CAP);
        @(negedge clk);
        add_frame(8'h41, 0);
        add_frame(8'h42, 0);
        wait_cycles(2 * FRAME_BITS + 6);
        compare_wave("b2b_div0");
        bus_read(A_ST, rd);  check("b2b_status_end", rd, 32'h10 | CAP);
        @(negedge clk);

        // overflow: one byte in the serializer, eight in the FIFO, tenth dropped
        bus_write(A_BD, 32'd100);
        bytes.delete();
        for (int i = 0; i < 10; i++) bytes.push_back(8'($urandom_range(0, 255)));
        begin_capture();
        foreach (bytes[i]) bus_write(A_TX, {24'b0, bytes[i]});
        bus_read(A_ST, rd);  check("ovf_status", rd, 32'hE8 | CAP);
        @(negedge clk);
        bus_write(A_ST, 32'hFF);
        bus_read(A_ST, rd);  check("ovf_cleared", rd, 32'h68 | CAP);
        @(negedge clk);
        for (int i = 0; i < 9; i++) add_frame(bytes[i], 100);
        wait_cycles(9 * FRAME_BITS * 101 + 10);
        compare_wave("ovf_order");
        check("ovf_tx_idle", tx_idle, 1);

        // randomized bursts
        for (int it = 0; it < 6; it++) begin
            d = $urandom_range(0, 4);
            n = $urandom_range(1, 4);
            bus_write(A_BD, d);
            begin_capture();
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                b = 8'($urandom_range(0, 255));
                bus_write(A_TX, {24'b0, b});
                add_frame(b, d);
            end
            wait_cycles(n * FRAME_BITS * (d + 1) + 8);
            compare_wave($sformatf("rand%0d", it));
        end

        // divisor change mid-frame applies from the next frame only
        bus_write(A_BD, 32'd2);
        begin_capture();
        bus_write(A_TX, 32'h3C);
        wait_cycles(5);
        bus_write(A_BD, 32'd5);
        bus_write(A_TX, 32'hC9);
        add_frame(8'h3C, 2);
        add_frame(8'hC9, 5);
        wait_cycles(FRAME_BITS * 9 + 8);
        compare_wave("div_change");

`ifdef IOBUS_UART_PARITY_EN
        bus_write(A_BD, 32'd1);
        begin_capture();
        bus_write(A_TX, 32'h07);
        add_frame(8'h07, 1);
        wait_cycles(30);
        check("parity_bit", tx_log[2 + 9 * 2], 1);
        check("parity_stop_end", tx_log[2 + 21], 1);
        compare_wave("parity_07");
`endif

        // unmapped / reserved accesses
        bus_write(A_BD, 32'd7);
        bus_write(A_RSV, 32'hFFFF_FFFF);
        bus_write(BASE + 32'h10, 32'h0000_0055);
        bus_read(A_RSV, rd);          check("rd_reserved", rd, 0);
        bus_read(BASE + 32'h10, rd);  check("rd_unmapped", rd, 0);
        bus_read(BASE + 32'h18, rd);  check("rd_unmapped_bd", rd, 0);
        bus_read(A_ST, rd);           check("rsv_status", rd, 32'h10 | CAP);
        bus_read(A_BD, rd);           check("rsv_bauddiv", rd, 32'd7);
        @(negedge clk);
        wait_cycles(4);
        check("rsv_tx_idle", tx_idle, 1);

        // reset mid-frame
        bus_write(A_BD, 32'd100);
        bus_write(A_TX, 32'h00);
        bus_write(A_TX, 32'h11);
        wait_cycles(30);
        check("mid_start_bit", tx, 0);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_idle", tx_idle, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(A_ST, rd);  check("post_rst_status", rd, 32'h10 | CAP);
        bus_read(A_BD, rd);  check("post_rst_bauddiv", rd, 32'd867);
        @(negedge clk);
        wait_cycles(5);
        check("post_rst_tx", tx, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
